// File: rtl/bb8051_fetch_queue_if.sv
// ROM fetch and decoder-side signals of the 8051 instruction prefetch queue.
// master = fetch queue, slave = ROM/decoder environment.
interface bb8051_fetch_queue_if;
  logic        rom_req;
  logic [15:0] rom_addr;
  logic [23:0] rom_data;
  logic        pc_load;
  logic [15:0] pc_load_addr;
  logic        decoder_wait;
  logic        instr_valid;
  logic [1:0]  instr_len;
  logic [15:0] instr_pc;
  logic [7:0]  op1_out;
  logic [7:0]  op2_out;
  logic [7:0]  op3_out;

  modport master (
    output rom_req, rom_addr, instr_valid, instr_len, instr_pc, op1_out, op2_out, op3_out,
    input  rom_data, pc_load, pc_load_addr, decoder_wait
  );

  modport slave (
    input  rom_req, rom_addr, instr_valid, instr_len, instr_pc, op1_out, op2_out, op3_out,
    output rom_data, pc_load, pc_load_addr, decoder_wait
  );
endinterface

// File: rtl/bb8051_fetch_queue.sv
// 8051 instruction prefetch queue: 3-byte ROM fetches into a byte ring,
// opcode length decode at the head, one aligned instruction per handshake.
module bb8051_fetch_queue #(
  parameter int unsigned DEPTH  = 8,
  parameter logic [15:0] RST_PC = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst,
  bb8051_fetch_queue_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = 16;
  localparam int unsigned BW = 8;

  logic [BW-1:0] mem_q [DEPTH];
  logic [BW-1:0] mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] fetch_addr_q, fetch_addr_d;
  logic [AW-1:0] instr_pc_q, instr_pc_d;
  logic          inflight_q, inflight_d;

  logic [BW-1:0] head0, head1, head2;
  logic [1:0]    head_len;
  logic          head_valid;
  logic          req;
  logic          do_write;
  logic          do_pop;

  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic [1:0] len;
    case (op) inside
      8'h02, 8'h10, 8'h12, 8'h20, 8'h30, 8'h43, 8'h53, 8'h63, 8'h75, 8'h85, 8'h90,
      8'hD5, [8'hB4:8'hBF]:
        len = 2'd3;
      8'h40, 8'h50, 8'h60, 8'h70, 8'h80,
      8'h05, 8'h15, 8'h25, 8'h35, 8'h45, 8'h55, 8'h65, 8'h95, 8'hC5, 8'hE5, 8'hF5,
      8'h24, 8'h34, 8'h44, 8'h54, 8'h64, 8'h74, 8'h94,
      8'h42, 8'h52, 8'h62, 8'h72, 8'h82, 8'h92, 8'hA0, 8'hA2, 8'hB0, 8'hB2,
      8'hC0, 8'hC2, 8'hD0, 8'hD2,
      [8'h76:8'h7F], [8'h86:8'h8F], [8'hA6:8'hAF], [8'hD8:8'hDF]:
        len = 2'd2;
      // AJMP/ACALL family: any opcode with low nibble 1
      default:
        len = (op[3:0] == 4'h1) ? 2'd2 : 2'd1;
    endcase
    return len;
  endfunction

  // Head decode and handshake qualifiers
  always_comb begin
    head0      = mem_q[rd_ptr_q];
    head1      = mem_q[rd_ptr_q + PW'(1)];
    head2      = mem_q[rd_ptr_q + PW'(2)];
    head_len   = op_len(head0);
    head_valid = (count_q != '0) && (count_q >= CW'(head_len));
    // Request only if the queue can absorb this fetch plus the one still returning
    req        = !rst && !bus.pc_load &&
                 ((32'(count_q) + (inflight_q ? 32'd3 : 32'd0) + 32'd3) <= DEPTH);
    do_write   = inflight_q && !bus.pc_load;
    do_pop     = head_valid && !bus.decoder_wait && !bus.pc_load;
  end

  // Next-state: redirect overrides pop, write and fetch
  always_comb begin
    mem_d        = mem_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    fetch_addr_d = fetch_addr_q;
    instr_pc_d   = instr_pc_q;
    inflight_d   = 1'b0;
    if (bus.pc_load) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      fetch_addr_d = bus.pc_load_addr;
      instr_pc_d   = bus.pc_load_addr;
    end else begin
      if (do_write) begin
        mem_d[wr_ptr_q]          = bus.rom_data[7:0];
        mem_d[wr_ptr_q + PW'(1)] = bus.rom_data[15:8];
        mem_d[wr_ptr_q + PW'(2)] = bus.rom_data[23:16];
        wr_ptr_d                 = wr_ptr_q + PW'(3);
      end
      if (do_pop) begin
        rd_ptr_d   = rd_ptr_q + PW'(head_len);
        instr_pc_d = instr_pc_q + AW'(head_len);
      end
      count_d    = count_q + (do_write ? CW'(3) : CW'(0)) - (do_pop ? CW'(head_len) : CW'(0));
      inflight_d = req;
      if (req) begin
        fetch_addr_d = fetch_addr_q + AW'(3);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q        <= '{default: '0};
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      fetch_addr_q <= RST_PC;
      instr_pc_q   <= RST_PC;
      inflight_q   <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      fetch_addr_q <= fetch_addr_d;
      instr_pc_q   <= instr_pc_d;
      inflight_q   <= inflight_d;
    end
  end

  // Decoder-facing outputs are combinational from registered state
  always_comb begin
    bus.rom_req     = req;
    bus.rom_addr    = fetch_addr_q;
    bus.instr_valid = head_valid;
    bus.instr_len   = head_valid ? head_len : 2'd0;
    bus.instr_pc    = instr_pc_q;
    bus.op1_out     = head_valid ? head0 : '0;
    bus.op2_out     = (head_valid && head_len >= 2'd2) ? head1 : '0;
    bus.op3_out     = (head_valid && head_len == 2'd3) ? head2 : '0;
  end
endmodule

// File: tb/tb_bb8051_fetch_queue.sv
// Bench for bb8051_fetch_queue: directed scenarios plus randomized traffic
// checked every cycle against a queue-based reference model.
module tb_bb8051_fetch_queue;
  localparam int unsigned DEPTH  = 8;
  localparam logic [15:0] RST_PC = 16'h0000;

  logic clk;
  logic rst;
  bb8051_fetch_queue_if bus();

  bb8051_fetch_queue #(.DEPTH(DEPTH), .RST_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rom [65536];
  logic [1:0] len_tab [256];
  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [7:0]  mq[$];
  logic [15:0] m_pc, m_fetch, m_infl_addr;
  logic        m_infl;
  logic [23:0] m_bytes;

  // sampled DUT outputs of the current cycle
  logic        s_req, s_valid;
  logic [15:0] s_addr, s_pc;
  logic [1:0]  s_len;
  logic [7:0]  s_op1, s_op2, s_op3;

  logic [7:0] l2 [37] = '{8'h40, 8'h50, 8'h60, 8'h70, 8'h80,
                          8'h05, 8'h15, 8'h25, 8'h35, 8'h45, 8'h55, 8'h65, 8'h95, 8'hC5, 8'hE5, 8'hF5,
                          8'h24, 8'h34, 8'h44, 8'h54, 8'h64, 8'h74, 8'h94,
                          8'h42, 8'h52, 8'h62, 8'h72, 8'h82, 8'h92, 8'hA0, 8'hA2, 8'hB0, 8'hB2,
                          8'hC0, 8'hC2, 8'hD0, 8'hD2};
  logic [7:0] l3 [12] = '{8'h02, 8'h12, 8'h10, 8'h20, 8'h30, 8'h43, 8'h53, 8'h63,
                          8'h75, 8'h85, 8'h90, 8'hD5};
  logic [7:0] px [9]  = '{8'h11, 8'hB5, 8'h85, 8'hA5, 8'hD8, 8'hE4, 8'h74, 8'h02, 8'h00};
  logic [1:0] pl [9]  = '{2'd2, 2'd3, 2'd3, 2'd1, 2'd2, 2'd1, 2'd2, 2'd3, 2'd1};

  function automatic logic [23:0] rom3(input logic [15:0] a);
    logic [15:0] a1, a2;
    a1 = a + 16'd1;
    a2 = a + 16'd2;
    return {rom[a2], rom[a1], rom[a]};
  endfunction

  function automatic logic [63:0] iv(input logic v, input logic [1:0] l, input logic [15:0] pc,
                                     input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return {21'd0, v, l, pc, a, b, c};
  endfunction

  function automatic logic [63:0] siv();
    return iv(s_valid, s_len, s_pc, s_op1, s_op2, s_op3);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: sample, compare against model, advance model, return ROM data
  task automatic tick();
    logic [1:0]  el;
    logic        ev, er, dreq;
    logic [7:0]  e1, e2, e3;
    logic [15:0] daddr;
    #1;
    s_req = bus.rom_req;     s_addr = bus.rom_addr;
    s_valid = bus.instr_valid; s_len = bus.instr_len; s_pc = bus.instr_pc;
    s_op1 = bus.op1_out;     s_op2 = bus.op2_out;    s_op3 = bus.op3_out;
    er = !rst && !bus.pc_load &&
         (mq.size() + (m_infl ? 3 : 0) + 3 <= int'(DEPTH));
    el = (mq.size() > 0) ? len_tab[mq[0]] : 2'd1;
    ev = (mq.size() >= 1) && (mq.size() >= int'(el));
    e1 = ev ? mq[0] : 8'h00;
    e2 = (ev && el >= 2'd2) ? mq[1] : 8'h00;
    e3 = (ev && el == 2'd3) ? mq[2] : 8'h00;
    if (rst) begin
      chk("reset_req", 64'(s_req), 64'(1'b0));
    end else begin
      chk("cycle", {4'd0, s_req, s_addr, s_valid, s_len, s_pc, s_op1, s_op2, s_op3},
          {4'd0, er, m_fetch, ev, (ev ? el : 2'd0), m_pc, e1, e2, e3});
    end
    if (rst) begin
      mq.delete(); m_pc = RST_PC; m_fetch = RST_PC; m_infl = 1'b0;
    end else if (bus.pc_load) begin
      mq.delete(); m_pc = bus.pc_load_addr; m_fetch = bus.pc_load_addr; m_infl = 1'b0;
    end else begin
      if (ev && !bus.decoder_wait) begin
        for (int i = 0; i < int'(el); i++) void'(mq.pop_front());
        m_pc = m_pc + 16'(el);
      end
      if (m_infl) begin
        mq.push_back(m_bytes[7:0]);
        mq.push_back(m_bytes[15:8]);
        mq.push_back(m_bytes[23:16]);
      end
      m_infl      = er;
      m_infl_addr = m_fetch;
      if (er) m_fetch = m_fetch + 16'd3;
    end
    dreq  = s_req;
    daddr = s_addr;
    @(posedge clk);
    #1;
    bus.rom_data = dreq ? rom3(daddr) : 24'($urandom);
    m_bytes      = rom3(m_infl_addr);
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.pc_load = 1'b0; bus.decoder_wait = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  logic [1:0]  swept [256];
  logic [15:0] req_addrs [4];
  int          npulse;
  logic        changed;
  logic [63:0] frozen;

  initial begin
    for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0] = 8'h74; rom[1] = 8'h55; rom[2] = 8'h02; rom[3] = 8'h12; rom[4] = 8'h34;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'(i);
      len_tab[i] = (b[3:0] == 4'h1) ? 2'd2 : 2'd1;
      if ((b >= 8'h76 && b <= 8'h7F) || (b >= 8'h86 && b <= 8'h8F) ||
          (b >= 8'hA6 && b <= 8'hAF) || (b >= 8'hD8 && b <= 8'hDF)) len_tab[i] = 2'd2;
    end
    foreach (l2[k]) len_tab[l2[k]] = 2'd2;
    foreach (l3[k]) len_tab[l3[k]] = 2'd3;
    for (int i = 8'hB4; i <= 8'hBF; i++) len_tab[i] = 2'd3;

    m_pc = RST_PC; m_fetch = RST_PC; m_infl = 1'b0; m_infl_addr = RST_PC; m_bytes = '0;
    rst = 1'b1; bus.pc_load = 1'b0; bus.pc_load_addr = '0;
    bus.decoder_wait = 1'b0; bus.rom_data = '0;

    // basic stream after reset
    do_reset();
    tick(); chk("t1_req0", 64'({s_req, s_addr}), 64'({1'b1, 16'h0000}));
    tick(); chk("t1_req1", 64'({s_req, s_addr}), 64'({1'b1, 16'h0003}));
    chk("t1_notvalid", 64'(s_valid), 64'(1'b0));
    tick(); chk("t1_i0", siv(), iv(1'b1, 2'd2, 16'h0000, 8'h74, 8'h55, 8'h00));
    tick(); chk("t1_i1", siv(), iv(1'b1, 2'd3, 16'h0002, 8'h02, 8'h12, 8'h34));
    tick(); chk("t1_i2", siv(), iv(1'b1, 2'd1, 16'h0005, 8'h00, 8'h00, 8'h00));

    // decoder stall holds the queue full, then drains without loss
    do_reset();
    bus.decoder_wait = 1'b1;
    npulse = 0; changed = 1'b0; frozen = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (s_req) begin
        if (npulse < 4) req_addrs[npulse] = s_addr;
        npulse++;
      end
      if (c == 2) frozen = siv();
      if (c > 2 && siv() !== frozen) changed = 1'b1;
    end
    chk("t2_pulses", 64'(npulse), 64'(2));
    chk("t2_addr0", 64'(req_addrs[0]), 64'(16'h0000));
    chk("t2_addr1", 64'(req_addrs[1]), 64'(16'h0003));
    chk("t2_stable", 64'(changed), 64'(1'b0));
    chk("t2_frozen", siv(), iv(1'b1, 2'd2, 16'h0000, 8'h74, 8'h55, 8'h00));
    bus.decoder_wait = 1'b0;
    tick(); chk("t2_i0", siv(), iv(1'b1, 2'd2, 16'h0000, 8'h74, 8'h55, 8'h00));
    tick(); chk("t2_i1", siv(), iv(1'b1, 2'd3, 16'h0002, 8'h02, 8'h12, 8'h34));
    tick(); chk("t2_i2", siv(), iv(1'b1, 2'd1, 16'h0005, 8'h00, 8'h00, 8'h00));

    // redirect with bytes queued and a fetch in flight
    rom[16'h0100] = 8'h74; rom[16'h0101] = 8'hAA; rom[16'h0102] = 8'h00;
    do_reset();
    bus.decoder_wait = 1'b1;
    tick(); tick();
    bus.pc_load = 1'b1; bus.pc_load_addr = 16'h0100;
    tick(); chk("t3_noreq_load", 64'(s_req), 64'(1'b0));
    bus.pc_load = 1'b0; bus.decoder_wait = 1'b0;
    tick(); chk("t3_after", 64'({s_valid, s_req, s_addr}), 64'({1'b0, 1'b1, 16'h0100}));
    tick(); chk("t3_gap", 64'(s_valid), 64'(1'b0));
    tick(); chk("t3_i0", siv(), iv(1'b1, 2'd2, 16'h0100, 8'h74, 8'hAA, 8'h00));

    // opcode length sweep
    for (int op = 0; op < 256; op++) begin
      rom[16'h2000] = 8'(op);
      bus.pc_load = 1'b1; bus.pc_load_addr = 16'h2000;
      tick();
      bus.pc_load = 1'b0;
      tick(); tick(); tick();
      swept[op] = s_len;
      chk("sweep_len", 64'({s_valid, s_len}), 64'({1'b1, len_tab[op]}));
    end
    foreach (px[k]) chk($sformatf("len_%02h", px[k]), 64'(swept[px[k]]), 64'(pl[k]));

    // fetch address wrap at the top of the address space
    rom[16'hFFFE] = 8'h90; rom[16'hFFFF] = 8'h12; rom[16'h0000] = 8'h34;
    bus.pc_load = 1'b1; bus.pc_load_addr = 16'hFFFE;
    tick();
    bus.pc_load = 1'b0;
    tick(); chk("t5_addr0", 64'({s_req, s_addr}), 64'({1'b1, 16'hFFFE}));
    tick(); chk("t5_addr1", 64'({s_req, s_addr}), 64'({1'b1, 16'h0001}));
    tick(); chk("t5_i0", siv(), iv(1'b1, 2'd3, 16'hFFFE, 8'h90, 8'h12, 8'h34));
    tick(); chk("t5_next_pc", 64'({s_valid, s_pc}), 64'({1'b1, 16'h0001}));
    rom[16'h0000] = 8'h74;

    // reset pulse while a fetch is in flight
    do_reset();
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(); chk("t6_restart", 64'({s_valid, s_req, s_addr}), 64'({1'b0, 1'b1, RST_PC}));
    tick();
    tick(); chk("t6_i0", siv(), iv(1'b1, 2'd2, 16'h0000, 8'h74, 8'h55, 8'h00));
    tick(); chk("t6_i1", siv(), iv(1'b1, 2'd3, 16'h0002, 8'h02, 8'h12, 8'h34));

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst              = ($urandom_range(0, 99) == 0);
      bus.pc_load      = ($urandom_range(0, 29) == 0);
      bus.pc_load_addr = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                                     : 16'($urandom);
      bus.decoder_wait = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
